mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Load/store sequencer between the MEM pipeline stage and the word-wide data memory (DM).
//  Turns LB/LBU/LH/LHU/LW/SB/SH/SW requests into DM word reads and writes.
//  Sub-word stores are done as read-modify-write, because DM has no byte enables.
//  Returns sign- or zero-extended load data and flags misaligned or out-of-range accesses.
// PARAMETERS
//  DM_AW   10   DM word-address width; DM address port is [DM_AW+1:2]
// PORTS
//  clk            in   1      system clock, all state changes on posedge
//  rst_n          in   1      asynchronous, active-low reset
//  req_valid      in   1      request present
//  req_ready      out  1      1 only in IDLE; a request is accepted when req_valid & req_ready at posedge
//  req_we         in   1      1 = store, 0 = load
//  req_size       in   2      00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
//  req_unsigned   in   1      loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr       in   32     byte address
//  req_wdata      in   32     store data; byte/half taken from the LSBs
//  rsp_valid      out  1      one-cycle pulse: load data or store ack
//  rsp_err        out  1      valid with rsp_valid: misaligned, illegal size, or addr[31:DM_AW+2]!=0
//  rsp_rdata      out  32     extended load data; 0 for stores and errors
//  dm_dmwr        out  1      DM control: 1 = write, 0 = read
//  dm_address     out  DM_AW  DM word address = latched addr[DM_AW+1:2]
//  dm_din         out  32     DM write data
//  dm_dout        in   32     DM read data; registered inside DM on the posedge where dm_dmwr=0
// BEHAVIOUR
//  Reset values: state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, dm_dmwr=0, dm_address=0, dm_din=0.
//  Byte order is little-endian: byte k of a word = bits [8k+7:8k].
//  Alignment: half requires addr[0]=0; word requires addr[1:0]=0.
//  On acceptance, addr, size, we, unsigned and wdata are latched; inputs are ignored until the next IDLE.
//  FSM transitions:
//   IDLE  -> on error: pulse rsp_valid with rsp_err=1 in the next cycle, stay in IDLE, no DM access.
//         -> on SW: WRITE.
//         -> on any load, SB or SH: READ.
//   READ  dm_dmwr=0, drives dm_address; DM captures dout at the closing edge. -> LOAD for loads, MERGE for stores.
//   LOAD  selects byte/half by addr[1:0] and extends it; registers rsp_rdata, sets rsp_valid. -> IDLE.
//   MERGE replaces the addressed byte/half of dm_dout with wdata LSBs; registers the result into dm_din. -> WRITE.
//   WRITE dm_dmwr=1; dm_din is full wdata for SW or the merged word; DM writes at the closing edge;
//         sets rsp_valid (store ack). -> IDLE.
//  dm_dmwr is 1 only in WRITE and 0 in every other state.
//  Latency from the accepting edge to rsp_valid high: error 1, SW 2, load 3, SB/SH 4 cycles.
//  rsp_valid lasts exactly one cycle and coincides with IDLE.
//  A new request may be accepted in the same cycle rsp_valid is high; there are no bubbles.
//  rsp_err=1 forces rsp_rdata=0.
//  Reset asserted mid-operation returns the FSM to IDLE immediately.
//   A SB/SH aborted before WRITE leaves memory unchanged; no rsp_valid is produced for the aborted request.
//  Back-to-back store then load to the same word: the load observes the stored value, because the DM write precedes the READ state.
// STRUCTURE
//  Package mem_pkg holds:
//   size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
//   the FSM state encoding IDLE/READ/LOAD/MERGE/WRITE (3 bits);
//   the alignment-check function.
//  Sub-module mem_load_ext: combinational byte/half lane select plus sign/zero extension, used in LOAD.
//  The store merge is inline in MERGE.
// TESTING
//  1. Preset DM word 0 = 32'h8899AABB.
//     LB addr 0x001 -> rsp_rdata=32'hFFFFFFAA, err=0.
//     LBU addr 0x001 -> rsp_rdata=32'h000000AA.
//     LH addr 0x002 -> rsp_rdata=32'hFFFF8899.
//     Each response arrives 3 cycles after accept.
//  2. SW 32'h12345678 to 0x010 -> ack 2 cycles after accept.
//     Then LW 0x010 -> 32'h12345678.
//  3. After test 2: SB 0xEE to 0x011 -> exactly one dm_dmwr=1 cycle, ack 4 cycles after accept.
//     LW 0x010 -> 32'h1234EE78.
//     SH 0xBEEF to 0x012 -> LW 0x010 returns 32'hBEEFEE78.
//  4. LH addr 0x003, LW addr 0x002, size 11, addr 0x0000_1000
//     -> each: rsp_err=1, rsp_rdata=0, 1-cycle latency, dm_dmwr never 1.
//  5. Assert rst_n=0 during the MERGE state of SB 0xFF to 0x020, where word 0x020 was 32'h0.
//     -> all outputs reach reset values asynchronously; no rsp_valid.
//     After reset, LW 0x020 = 32'h0.
//  6. Hold req_valid=1 with SW, LW, SW, LW alternating to one address
//     -> each load returns the preceding store data.
//     Each new request is accepted in the cycle its predecessor's rsp_valid is high.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings, request record and alignment check for the load/store sequencer
//   SZ_*      access size encodings carried on req_size
//   IDLE..    FSM state encoding (3 bits)
//   req_t     request fields latched at acceptance
//   misaligned() flags illegal size or misaligned offset
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] MERGE = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] wdata;
    } req_t;

    // Size 11 has no legal encoding, so it is reported as misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00) || size == 2'b11;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: selects the addressed byte/half of a DM word and sign/zero extends it
//   word  in  32  DM read word
//   off   in  2   byte offset within the word
//   size  in  2   access size
//   uns   in  1   1 = zero-extend, 0 = sign-extend
//   data  out 32  extended load data
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = word[{off, 3'b000} +: 8];
        h    = off[1] ? word[31:16] : word[15:0];
        data = size == SZ_BYTE ? {{24{b[7] & ~uns}}, b} :
               size == SZ_HALF ? {{16{h[15] & ~uns}}, h} : word;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer between the MEM stage and a word-wide data memory
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake, ready only in IDLE
//   req_we/size/unsigned/addr/wdata   request fields, latched on acceptance
//   rsp_valid/rsp_err/rsp_rdata       one-cycle response pulse with extended load data
//   dm_dmwr/dm_address/dm_din/dm_dout data memory port (registered read inside DM)
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DM_AW = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [31:0]      rsp_rdata,
    output logic             dm_dmwr,
    output logic [DM_AW-1:0] dm_address,
    output logic [31:0]      dm_din,
    input  logic [31:0]      dm_dout
);

    logic [2:0]  state;
    req_t        r;
    logic        acc;
    logic        err;
    logic [31:0] ld;
    logic [31:0] mask;
    logic [31:0] merged;

    mem_load_ext u_ext (
        .word(dm_dout),
        .off (r.off),
        .size(r.size),
        .uns (r.uns),
        .data(ld)
    );

    always_comb begin
        req_ready = state == IDLE;
        dm_dmwr   = state == WRITE;
        acc       = req_valid && req_ready;
        err       = misaligned(req_size, req_addr[1:0]) || req_addr[31:DM_AW+2] != '0;
        // Lane mask of the bytes being replaced; the store data is shifted into the same lanes.
        mask      = r.size == SZ_BYTE ? 32'h0000_00FF << {r.off, 3'b000} : 32'h0000_FFFF << {r.off[1], 4'b0000};
        merged    = (dm_dout & ~mask) | ((r.wdata << (r.size == SZ_BYTE ? {r.off, 3'b000} : {r.off[1], 4'b0000})) & mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            r          <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            dm_address <= '0;
            dm_din     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                IDLE: if (acc) begin
                    r          <= '{we: req_we, size: req_size, uns: req_unsigned, off: req_addr[1:0], wdata: req_wdata};
                    dm_address <= req_addr[DM_AW+1:2];
                    if (err) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (req_we && req_size == SZ_WORD) begin
                        dm_din <= req_wdata;
                        state  <= WRITE;
                    end else begin
                        state <= READ;
                    end
                end
                READ:  state <= r.we ? MERGE : LOAD;
                LOAD: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ld;
                    state     <= IDLE;
                end
                MERGE: begin
                    dm_din <= merged;
                    state  <= WRITE;
                end
                WRITE: begin
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl with a behavioural DM
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        dm_dmwr;
    logic [9:0]  dm_address;
    logic [31:0] dm_din;
    logic [31:0] dm_dout = '0;

    logic [31:0] mem [0:1023];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DM_AW(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .dm_dmwr(dm_dmwr), .dm_address(dm_address), .dm_din(dm_din), .dm_dout(dm_dout)
    );

    always @(posedge clk) begin
        if (dm_dmwr) mem[dm_address] <= dm_din;
        else dm_dout <= mem[dm_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er, output int wrs);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        wrs = 0; lat = 99; rd = 'x; er = 1'bx;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (dm_dmwr) wrs++;
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
    endtask

    int          lat, wrs, k;
    logic [31:0] rd;
    logic        er;
    logic        seen;
    logic        s_we   [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] s_wd   [0:4] = '{32'hCAFE_F00D, 32'h0, 32'h0BAD_BEEF, 32'h0, 32'h0};
    logic [31:0] s_exp  [0:3] = '{32'h0, 32'hCAFE_F00D, 32'h0, 32'h0BAD_BEEF};
    int          s_lat  [0:3] = '{2, 3, 2, 3};

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h8899_AABB;
        #12;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_dmwr", {31'b0, dm_dmwr}, 32'd0);
        chk("rst_addr", {22'b0, dm_address}, 32'h0);
        chk("rst_din", dm_din, 32'h0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;

        do_req(1'b0, 2'b00, 1'b0, 32'h001, 32'h0, lat, rd, er, wrs);
        chk("lb_data", rd, 32'hFFFF_FFAA); chk("lb_err", {31'b0, er}, 32'd0); chk("lb_lat", lat, 3);
        do_req(1'b0, 2'b00, 1'b1, 32'h001, 32'h0, lat, rd, er, wrs);
        chk("lbu_data", rd, 32'h0000_00AA); chk("lbu_lat", lat, 3);
        do_req(1'b0, 2'b01, 1'b0, 32'h002, 32'h0, lat, rd, er, wrs);
        chk("lh_data", rd, 32'hFFFF_8899); chk("lh_lat", lat, 3);
        do_req(1'b0, 2'b01, 1'b1, 32'h000, 32'h0, lat, rd, er, wrs);
        chk("lhu_data", rd, 32'h0000_AABB);

        do_req(1'b1, 2'b10, 1'b0, 32'h010, 32'h1234_5678, lat, rd, er, wrs);
        chk("sw_lat", lat, 2); chk("sw_rdata", rd, 32'h0); chk("sw_wrs", wrs, 1);
        do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, lat, rd, er, wrs);
        chk("lw_after_sw", rd, 32'h1234_5678);

        do_req(1'b1, 2'b00, 1'b0, 32'h011, 32'h0000_00EE, lat, rd, er, wrs);
        chk("sb_lat", lat, 4); chk("sb_wrs", wrs, 1);
        do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, lat, rd, er, wrs);
        chk("lw_after_sb", rd, 32'h1234_EE78);
        do_req(1'b1, 2'b01, 1'b0, 32'h012, 32'h0000_BEEF, lat, rd, er, wrs);
        chk("sh_lat", lat, 4);
        do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, lat, rd, er, wrs);
        chk("lw_after_sh", rd, 32'hBEEF_EE78);

        do_req(1'b0, 2'b01, 1'b0, 32'h003, 32'h0, lat, rd, er, wrs);
        chk("err_lh_err", {31'b0, er}, 32'd1); chk("err_lh_rd", rd, 32'h0); chk("err_lh_lat", lat, 1); chk("err_lh_wr", wrs, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h002, 32'h0, lat, rd, er, wrs);
        chk("err_lw_err", {31'b0, er}, 32'd1); chk("err_lw_lat", lat, 1);
        do_req(1'b1, 2'b11, 1'b0, 32'h000, 32'hFFFF_FFFF, lat, rd, er, wrs);
        chk("err_sz_err", {31'b0, er}, 32'd1); chk("err_sz_lat", lat, 1); chk("err_sz_wr", wrs, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, lat, rd, er, wrs);
        chk("err_rng_err", {31'b0, er}, 32'd1); chk("err_rng_rd", rd, 32'h0); chk("err_rng_lat", lat, 1);
        do_req(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, lat, rd, er, wrs);
        chk("lw_word0_intact", rd, 32'h8899_AABB);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h020; req_wdata = 32'h0000_00FF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort_dmwr", {31'b0, dm_dmwr}, 32'd0);
        chk("abort_addr", {22'b0, dm_address}, 32'h0);
        chk("abort_din", dm_din, 32'h0);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid || dm_dmwr) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid || dm_dmwr) seen = 1'b1;
        end
        chk("abort_quiet", {31'b0, seen}, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, lat, rd, er, wrs);
        chk("abort_mem", rd, 32'h0);

        @(negedge clk);
        req_valid = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h040;
        req_we = s_we[0]; req_wdata = s_wd[0];
        @(posedge clk);
        #1 req_we = s_we[1]; req_wdata = s_wd[1];
        for (int s = 0; s < 4; s++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!rsp_valid && k < 10);
            chk($sformatf("b2b_lat%0d", s), k, s_lat[s]);
            chk($sformatf("b2b_data%0d", s), rsp_rdata, s_exp[s]);
            chk($sformatf("b2b_ready%0d", s), {31'b0, req_ready}, 32'd1);
            if (s == 3) req_valid = 1'b0;
            @(posedge clk);
            #1 req_we = s_we[s+2 > 4 ? 4 : s+2]; req_wdata = s_wd[s+2 > 4 ? 4 : s+2];
        end
        @(negedge clk);
        chk("b2b_idle", {31'b0, req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
